seq_control_unit: RTL and testbench
===================================

# seq_control_unit

Multi-cycle, parametrised control sequencer for the 16-bit processor. It owns the fetch/decode/execute/memory/writeback sequence internally and no longer relies on an external state machine. It adds a memory ready handshake with a timeout, flag-conditional branches, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register opcode field, the ALU flag register, memory, the PC and the register file.

## Interface
Parameters:
- OP_W, 4: opcode width, at least 4. Opcode values 16 and above are illegal.
- ALU_W, 4: alu_func width, at least 4. Upper bits are zero-filled.
- TIMEOUT, 15: maximum cycles spent waiting for mem_ready, per access.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run enable, sampled only in IDLE and WRITEBACK.
- op  in  OP_W  opcode field from the IR, sampled in DECODE.
- flag_z, flag_n  in  1  ALU zero/negative flags, sampled in EXECUTE.
- mem_ready  in  1  memory access complete this cycle.
- ir_load, pc_inc, pc_load  out  1  single-cycle strobes.
- immed_sel, w_en, flag_en, mem_sel, mem_en, pc_sel, mar_sel  out  1  datapath controls.
- alu_func  out  ALU_W  ALU operation.
- state  out  3  current state encoding.
- busy  out  1  high whenever state is not IDLE and not TRAP.
- trap  out  1  high in TRAP.
- instr_count  out  CNT_W  number of retired instructions.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, TRAP=6.
- All outputs are decoded combinationally from the registered state, op_q (the latched opcode) and taken_q.
- IDLE: all controls are 0. If en=1, go to FETCH.
- FETCH:
  - Drives mem_en=1, mar_sel=0.
  - On mem_ready: ir_load=1 and pc_inc=1 for that cycle, then go to DECODE.
- DECODE: latch op into op_q.
  - If op is 16 or above, go to TRAP.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - alu_func and immed_sel are valid here and through WRITEBACK.
  - alu_func: 0 for JMP; op for 1–0xC; 0xD for 0xD–0xF.
  - immed_sel=0 for op 1–4 and 7; otherwise 1.
  - taken_q is latched: JMP=1; BNE(0xD)=!flag_z; BLT(0xE)=flag_n; BE(0xF)=flag_z; all others 0.
  - LD(5) and ST(6) go to MEM. All other ops go to WRITEBACK.
- MEM:
  - Drives mem_en=1 and mar_sel=1; mem_sel=1 only for ST.
  - On mem_ready, go to WRITEBACK.
- WRITEBACK:
  - w_en=1 for ops 1–5 and 7–0xC.
  - flag_en=1 for ops 1, 2, 8, 9, 0xA.
  - pc_sel=1 for op 0 and 0xD–0xF.
  - pc_load=taken_q.
  - instr_count increments, wrapping at 2^CNT_W.
  - Next state is FETCH if en=1, else IDLE.
- Memory timeout:
  - A wait counter clears on entry to FETCH or MEM and increments for each cycle spent there with mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0, go to TRAP.
  - mem_ready arriving in that same cycle wins; no trap.
- TRAP: all controls 0 and trap=1. Exit is by reset only.
- An en falling mid-instruction is ignored; the instruction completes.

## Timing
- Reset (asynchronous):
  - state=IDLE; op_q, taken_q, wait counter and instr_count cleared to 0.
  - Every output is 0 while reset is high.
- Single-cycle memory (mem_ready always 1):
  - Non-memory instruction: 4 cycles, FETCH→DECODE→EXECUTE→WRITEBACK.
  - LD/ST: 5 cycles.
- Each cycle with mem_ready=0 in FETCH or MEM adds one cycle of latency.
- ir_load and pc_inc assert only in the FETCH cycle where mem_ready=1.
- w_en, flag_en, pc_load and the instr_count update assert only in the WRITEBACK cycle.
- First FETCH occurs 1 cycle after en is sampled high in IDLE.

## Test plan
- Reset mid-MEM with mem_ready=0 → state=0 and all outputs 0 immediately; instr_count=0.
- en=1, mem_ready=1, op=1 (ADDS) → states 1,2,3,5 on consecutive cycles. In WRITEBACK: alu_func=1, immed_sel=0, w_en=1, flag_en=1. instr_count=1 after the WRITEBACK edge.
- op=5 (LD), mem_ready held low for 3 MEM cycles → MEM lasts 4 cycles, mar_sel=1, mem_sel=0, w_en=1 in WRITEBACK. op=6 (ST) → mem_sel=1 in MEM, w_en=0.
- Branches, flags sampled in EXECUTE:
  - op=0xD, flag_z=1 → pc_load=0, pc_sel=1.
  - op=0xD, flag_z=0 → pc_load=1.
  - op=0xE, flag_n=1 → pc_load=1.
  - op=0 → pc_load=1, alu_func=0.
- Timeout, TIMEOUT=15:
  - mem_ready=0 for 15 FETCH cycles → TRAP, trap=1, busy=0, held with en=1.
  - mem_ready=1 on the 15th cycle → DECODE, no trap.
- Illegal opcode, OP_W=5, op=0x10 → TRAP after DECODE; w_en never asserts. Also: CNT_W=4 with 17 retired instructions → instr_count=1.

Source files
------------

// File: rtl/seq_control_unit_if.sv
// Control bus between the sequencer and the datapath/memory: opcode and flags in,
// memory handshake and datapath strobes/selects out.
interface seq_control_unit_if #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned ALU_W = 4
);
  logic [OP_W-1:0]  op;
  logic             flag_z;
  logic             flag_n;
  logic             mem_ready;

  logic             ir_load;
  logic             pc_inc;
  logic             pc_load;
  logic             immed_sel;
  logic             w_en;
  logic             flag_en;
  logic             mem_sel;
  logic             mem_en;
  logic             pc_sel;
  logic             mar_sel;
  logic [ALU_W-1:0] alu_func;

  // Sequencer side
  modport master (
    input  op, flag_z, flag_n, mem_ready,
    output ir_load, pc_inc, pc_load, immed_sel, w_en, flag_en,
           mem_sel, mem_en, pc_sel, mar_sel, alu_func
  );

  // Datapath / memory side
  modport slave (
    output op, flag_z, flag_n, mem_ready,
    input  ir_load, pc_inc, pc_load, immed_sel, w_en, flag_en,
           mem_sel, mem_en, pc_sel, mar_sel, alu_func
  );
endinterface

// File: rtl/seq_control_unit.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with memory-ready timeout,
// flag-conditional branches, illegal-opcode trap and a retired-instruction counter.
module seq_control_unit #(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned ALU_W   = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  seq_control_unit_if.master bus,
  output logic [2:0]       state,
  output logic             busy,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [3:0] OP_JMP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_BNE = 4'hD;
  localparam logic [3:0] OP_BLT = 4'hE;
  localparam logic [3:0] OP_BE  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        op_q;
  logic              taken_q;
  logic              taken_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              op_illegal;
  logic              mem_timeout;

  // Per-opcode decode of the latched opcode
  logic [ALU_W-1:0]  alu_dec;
  logic              immed_dec;
  logic              w_en_dec;
  logic              flag_en_dec;
  logic              pc_sel_dec;

  assign op_illegal  = (32'(bus.op) > 32'd15);
  assign mem_timeout = (wait_cnt == WAIT_LAST);

  always_comb begin
    alu_dec     = '0;
    immed_dec   = 1'b1;
    w_en_dec    = 1'b0;
    flag_en_dec = 1'b0;
    pc_sel_dec  = 1'b0;
    taken_d     = 1'b0;

    if (op_q == OP_JMP)
      alu_dec = '0;
    else if (op_q <= 4'hC)
      alu_dec = ALU_W'(op_q);
    else
      alu_dec = ALU_W'(4'hD);

    if (((op_q >= 4'h1) && (op_q <= 4'h4)) || (op_q == 4'h7))
      immed_dec = 1'b0;

    w_en_dec    = (op_q != OP_JMP) && (op_q != OP_ST) && (op_q <= 4'hC);
    flag_en_dec = (op_q == 4'h1) || (op_q == 4'h2) || (op_q == 4'h8) ||
                  (op_q == 4'h9) || (op_q == 4'hA);
    pc_sel_dec  = (op_q == OP_JMP) || (op_q >= OP_BNE);

    // Branch outcome, captured from the flags while in EXECUTE
    case (op_q)
      OP_JMP:  taken_d = 1'b1;
      OP_BNE:  taken_d = ~bus.flag_z;
      OP_BLT:  taken_d = bus.flag_n;
      OP_BE:   taken_d = bus.flag_z;
      default: taken_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.ir_load   = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.pc_load   = 1'b0;
    bus.immed_sel = 1'b0;
    bus.w_en      = 1'b0;
    bus.flag_en   = 1'b0;
    bus.mem_sel   = 1'b0;
    bus.mem_en    = 1'b0;
    bus.pc_sel    = 1'b0;
    bus.mar_sel   = 1'b0;
    bus.alu_func  = '0;

    case (state_q)
      S_IDLE: begin
        if (en)
          state_d = S_FETCH;
      end

      S_FETCH: begin
        bus.mem_en = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_load = 1'b1;
          bus.pc_inc  = 1'b1;
          state_d     = S_DECODE;
        end else if (mem_timeout) begin
          state_d = S_TRAP;
        end
      end

      S_DECODE: begin
        state_d = op_illegal ? S_TRAP : S_EXECUTE;
      end

      S_EXECUTE: begin
        bus.alu_func  = alu_dec;
        bus.immed_sel = immed_dec;
        state_d = ((op_q == OP_LD) || (op_q == OP_ST)) ? S_MEM : S_WRITEBACK;
      end

      S_MEM: begin
        bus.alu_func  = alu_dec;
        bus.immed_sel = immed_dec;
        bus.mem_en    = 1'b1;
        bus.mar_sel   = 1'b1;
        bus.mem_sel   = (op_q == OP_ST);
        if (bus.mem_ready)
          state_d = S_WRITEBACK;
        else if (mem_timeout)
          state_d = S_TRAP;
      end

      S_WRITEBACK: begin
        bus.alu_func  = alu_dec;
        bus.immed_sel = immed_dec;
        bus.w_en      = w_en_dec;
        bus.flag_en   = flag_en_dec;
        bus.pc_sel    = pc_sel_dec;
        bus.pc_load   = taken_q;
        state_d       = en ? S_FETCH : S_IDLE;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Opcode/branch latches, memory wait counter and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= '0;
      taken_q     <= 1'b0;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      if (state_q == S_DECODE)
        op_q <= bus.op[3:0];

      if (state_q == S_EXECUTE)
        taken_q <= taken_d;

      // Any state change restarts the count, so FETCH/MEM always enter at zero
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);

      if (state_q == S_WRITEBACK)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign state = 3'(state_q);
  assign busy  = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign trap  = (state_q == S_TRAP);

endmodule

// File: tb/tb_seq_control_unit.sv
// Randomized bench for seq_control_unit against an instruction-level reference model.
`timescale 1ns/1ps
module tb_seq_control_unit;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 4;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3,
                 ST_MEM = 4, ST_WB = 5, ST_TRAP = 6;

  // Opcode property tables, bit i = opcode i
  localparam logic [15:0] W_MASK   = 16'h1FBE;
  localparam logic [15:0] FL_MASK  = 16'h0706;
  localparam logic [15:0] PCS_MASK = 16'hE001;
  localparam logic [15:0] IMM_MASK = 16'hFF61;

  logic             clk;
  logic             reset;
  logic             en;
  logic [2:0]       state;
  logic             busy;
  logic             trap;
  logic [CNT_W-1:0] instr_count;

  seq_control_unit_if #(.OP_W(OP_W), .ALU_W(ALU_W)) bus ();

  seq_control_unit #(.OP_W(OP_W), .ALU_W(ALU_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .bus(bus.master),
    .state(state), .busy(busy), .trap(trap), .instr_count(instr_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int retired  = 0;
  bit at_idle  = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int alu_of(input int mop);
    if (mop == 0) return 0;
    if (mop >= 13) return 13;
    return mop;
  endfunction

  function automatic bit branch_taken(input int mop, input bit fz, input bit fn);
    case (mop)
      0:       return 1'b1;
      13:      return !fz;
      14:      return fn;
      15:      return fz;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs from the state the model says the DUT is in
  task automatic check_cycle(input string tag, input int st, input int mop, input bit taken, input bit rdy);
    logic [9:0] e_ctrl;
    logic [9:0] o_ctrl;
    int e_alu;
    int m;
    m = mop & 15;
    e_ctrl = '0;
    e_alu = 0;
    if (st == ST_FETCH) begin
      e_ctrl[2] = 1'b1;
      e_ctrl[9] = rdy;
      e_ctrl[8] = rdy;
    end
    if (st == ST_EXEC || st == ST_MEM || st == ST_WB) begin
      e_alu = alu_of(m);
      e_ctrl[6] = IMM_MASK[m];
    end
    if (st == ST_MEM) begin
      e_ctrl[2] = 1'b1;
      e_ctrl[0] = 1'b1;
      e_ctrl[3] = (m == 6);
    end
    if (st == ST_WB) begin
      e_ctrl[5] = W_MASK[m];
      e_ctrl[4] = FL_MASK[m];
      e_ctrl[1] = PCS_MASK[m];
      e_ctrl[7] = taken;
    end
    o_ctrl = {bus.ir_load, bus.pc_inc, bus.pc_load, bus.immed_sel, bus.w_en,
              bus.flag_en, bus.mem_sel, bus.mem_en, bus.pc_sel, bus.mar_sel};
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_ctrl"}, 32'(o_ctrl), 32'(e_ctrl));
    check({tag, "_alu"}, 32'(bus.alu_func), 32'(e_alu));
    check({tag, "_busy_trap"}, 32'({busy, trap}),
          32'({(st != ST_IDLE && st != ST_TRAP), (st == ST_TRAP)}));
    check({tag, "_count"}, 32'(instr_count), 32'(retired % 16));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    en = 1'b1;
    bus.mem_ready = 1'b1;
    retired = 0;
    #1 check_cycle("reset", ST_IDLE, 0, 0, 0);
    step();
    #1 check_cycle("reset_hold", ST_IDLE, 0, 0, 0);
    en = 1'b0;
    reset = 1'b0;
    at_idle = 1;
  endtask

  task automatic start_from_idle();
    step();
    en = 1'b1;
    bus.mem_ready = 1'($urandom);
    #1 check_cycle("idle", ST_IDLE, 0, 0, 0);
    at_idle = 0;
  endtask

  // One memory wait phase: fw cycles of mem_ready=0, then ready (or timeout)
  task automatic wait_phase(input string tag, input int st, input int mop, input int fw, output bit timed_out);
    bit rdy;
    timed_out = 0;
    for (int i = 0; i <= fw && i < int'(TIMEOUT); i++) begin
      step();
      rdy = (i == fw);
      bus.mem_ready = rdy;
      en = 1'($urandom);
      bus.flag_z = 1'($urandom);
      bus.flag_n = 1'($urandom);
      if (st == ST_FETCH) bus.op = OP_W'($urandom);
      #1 check_cycle(tag, st, mop, 0, rdy);
    end
    if (fw >= int'(TIMEOUT)) timed_out = 1;
  endtask

  task automatic run_instr(input int mop, input int fw, input int mw, input bit fz, input bit fn,
                           input bit en_nx, output bit trapped);
    bit tk;
    bit to;
    trapped = 0;
    wait_phase("fetch", ST_FETCH, 0, fw, to);
    if (to) begin trapped = 1; return; end
    step();
    bus.op = OP_W'(mop);
    bus.mem_ready = 1'($urandom);
    #1 check_cycle("decode", ST_DECODE, 0, 0, 0);
    if (mop >= 16) begin trapped = 1; return; end
    tk = branch_taken(mop, fz, fn);
    step();
    bus.op = OP_W'($urandom);
    bus.flag_z = fz;
    bus.flag_n = fn;
    #1 check_cycle("exec", ST_EXEC, mop, 0, 0);
    if (mop == 5 || mop == 6) begin
      wait_phase("mem", ST_MEM, mop, mw, to);
      if (to) begin trapped = 1; return; end
    end
    step();
    en = en_nx;
    bus.flag_z = 1'($urandom);
    bus.flag_n = 1'($urandom);
    bus.mem_ready = 1'($urandom);
    #1 check_cycle("wb", ST_WB, mop, tk, 0);
    retired++;
  endtask

  task automatic expect_trap(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      en = 1'b1;
      bus.mem_ready = 1'($urandom);
      #1 check_cycle("trap", ST_TRAP, 0, 0, 0);
    end
  endtask

  task automatic go(input int mop, input int fw, input int mw, input bit fz, input bit fn, input bit en_nx);
    bit trapped;
    if (at_idle) start_from_idle();
    run_instr(mop, fw, mw, fz, fn, en_nx, trapped);
    if (trapped) begin
      expect_trap(3);
      do_reset();
    end else begin
      at_idle = !en_nx;
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom % 40);
    if (r == 0) return int'(TIMEOUT);
    if (r == 1) return int'(TIMEOUT) - 1;
    if (r < 8) return 1 + int'($urandom % 3);
    return 0;
  endfunction

  initial begin
    bit to;
    reset = 1'b1;
    en = 1'b0;
    bus.op = '0;
    bus.flag_z = 1'b0;
    bus.flag_n = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    #1 check_cycle("por", ST_IDLE, 0, 0, 0);
    reset = 1'b0;

    // Reset while an LD waits in MEM
    start_from_idle();
    wait_phase("fetch", ST_FETCH, 0, 0, to);
    step(); bus.op = OP_W'(5); #1 check_cycle("decode", ST_DECODE, 0, 0, 0);
    step(); #1 check_cycle("exec", ST_EXEC, 5, 0, 0);
    step(); bus.mem_ready = 1'b0; #1 check_cycle("mem", ST_MEM, 5, 0, 0);
    #2 reset = 1'b1;
    #1 check_cycle("rst_mid_mem", ST_IDLE, 0, 0, 0);
    step(); reset = 1'b0; en = 1'b0;
    at_idle = 1;

    // Directed instructions
    go(1, 0, 0, 0, 0, 1);
    go(5, 0, 3, 0, 0, 1);
    go(6, 1, 0, 0, 0, 1);
    go(13, 0, 0, 1, 0, 1);
    go(13, 0, 0, 0, 1, 1);
    go(14, 0, 0, 0, 1, 1);
    go(15, 2, 0, 1, 0, 1);
    go(0, 0, 0, 0, 0, 0);
    go(7, int'(TIMEOUT) - 1, 0, 0, 0, 1);
    go(5, 0, int'(TIMEOUT) - 1, 0, 0, 0);
    go(3, int'(TIMEOUT), 0, 0, 0, 1);
    go(16, 0, 0, 0, 0, 1);
    go(6, 0, int'(TIMEOUT), 0, 0, 1);

    // Counter wrap: 17 retirements from reset
    for (int i = 0; i < 17; i++)
      go(int'($urandom % 16), 0, 0, 1'($urandom), 1'($urandom), i != 16);
    step();
    #1 check("cnt_wrap", 32'(instr_count), 32'd1);
    do_reset();

    // Random instruction stream
    for (int i = 0; i < 250; i++) begin
      int mop;
      mop = ($urandom % 20 == 0) ? 16 + int'($urandom % 16) : int'($urandom % 16);
      go(mop, pick_wait(), pick_wait(), 1'($urandom), 1'($urandom), ($urandom % 4) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
